fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
Round-robin write-port arbiter that shares the single write port of the team's 32x8 FIFO among N requesters. Each requester presents a word with a level request. The arbiter grants one owner for a burst of up to BURST words and drives the FIFO's WRITE and data input. It throttles on FIFO occupancy so no accepted word is ever dropped on a full FIFO.

Parameters:
N, 4, number of requesters (2..8)
size, 8, data word width; must match the FIFO's size
tam, 32, FIFO depth; must match the FIFO's tam
BURST, 4, maximum words accepted from one owner before rotation (1..15)

Ports:
CLOCK  input  1  system clock, rising edge
RESET_N  input  1  asynchronous active-low reset
CLEAR_N  input  1  synchronous active-low clear; same effect as reset, applied on a clock edge
REQ  input  N  REQ[n]=1: requester n holds a valid word on its DATA_REQ slice
DATA_REQ  input  N*size  flattened words; requester n occupies bits [n*size +: size]
ACK  output  N  one-hot; ACK[n]=1: requester n's word is consumed at this edge
F_FULL_N  input  1  FIFO full flag, active-low
USE_DW  input  6  FIFO occupancy; updates the cycle after a write
WRITE  output  1  registered write strobe to the FIFO
FIFO_DATA  output  size  registered word to the FIFO's DATA_IN
OWNER  output  $clog2(N)  index of the current or last owner
BUSY  output  1  1 while in BURST or STALL

Behaviour:
- Reset or CLEAR_N=0 produces: state IDLE, WRITE=0, FIFO_DATA=0, OWNER=0, rr pointer=0, burst count=0, ACK=0, BUSY=0.
- Space rule: space = F_FULL_N && (USE_DW + WRITE) < tam. WRITE here is the registered strobe, which covers the one-cycle occupancy lag.
- ACK is combinational. ACK[OWNER] = (state==BURST) && REQ[OWNER] && space.
- When ACK[n]=1, the next edge sets WRITE=1 and FIFO_DATA=DATA_REQ slice n. Otherwise WRITE=0 and FIFO_DATA holds. Latency from accept to FIFO write is 1 cycle.
- Requesters must hold REQ and data stable until ACK. ACK implies the word is gone; a requester may then present the next word in the same cycle.
- IDLE:
  - If any REQ is set, OWNER becomes the first requester at or after the rr pointer (cyclic search), count=0, and the next state is BURST.
  - No ACK is issued in IDLE, so grant latency is 1 cycle.
- BURST:
  - Each ACK increments count.
  - If ACK and count+1==BURST, or REQ[OWNER]==0, the burst ends: rr pointer = OWNER+1 mod N, and the next state is IDLE.
  - If REQ[OWNER]=1 and no space, the next state is STALL.
- STALL:
  - OWNER is held and ACK=0.
  - When space returns, the next state is BURST.
  - If REQ[OWNER] drops, the burst ends as above.
- Boundaries:
  - Simultaneous requests are resolved strictly by the rr pointer; no requester waits more than (N-1) bursts.
  - The pointer wraps N-1 to 0.
  - USE_DW==tam-1 with WRITE=1 counts as no space.
  - CLEAR_N mid-burst discards the pending WRITE; the word already ACKed is lost. Upstream must pair CLEAR_N with a FIFO clear.
- The arbiter never asserts READ; the FIFO read side is out of scope.

Optional Feature:
FIFO_ARB_PRIO0_EN:
- Defined: requester 0 is urgent. In IDLE it wins whenever REQ[0]=1, regardless of the rr pointer. In BURST with another owner, REQ[0]=1 ends that burst after its current ACK: the pointer advances past the preempted owner, and requester 0 is granted next.
- Not defined: pure round-robin as above.

Decomposition:
- Package fifo_arb_pkg holds:
  - the state enum {IDLE, BURST, STALL} as logic [1:0]
  - default constants for N, size, tam, BURST
  - a function rr_pick(req, ptr) returning the first set index at or after ptr
- One natural sub-module: rr_selector (combinational cyclic priority encoder, N inputs plus pointer, outputs index and valid). The FSM, count and output registers stay in fifo_wr_arbiter.
- The bench instantiates FIFO32x8 behind the arbiter.

Test Plan:
- Single requester, REQ[2]=1 for 6 words, BURST=4, FIFO empty -> grant 1 cycle after REQ, ACK[2] on 4 consecutive cycles, IDLE, regrant, 2 more ACKs; WRITE follows each ACK by 1 cycle; FIFO holds the words in order.
- REQ=4'b1111 held -> bursts of 4 in order 0,1,2,3,0; OWNER sequence matches; no ACK in IDLE cycles.
- Preload FIFO to 30 words, REQ[1]=1 -> exactly 2 ACKs, then STALL with ACK=0 and USE_DW=32. After external reads, BURST resumes; no overflow.
- RESET_N pulled low mid-burst, asynchronously and between edges -> WRITE, ACK, BUSY drop immediately and OWNER=0; after release, arbitration restarts at requester 0.
- REQ[3] dropped during STALL -> IDLE, rr pointer=0; next REQ[0] is granted.
- With FIFO_ARB_PRIO0_EN, requester 2 in a burst and REQ[0] rising -> requester 2 is cut after its next ACK, OWNER=0 on the following grant, then requester 3.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared state encoding, default sizes and round-robin pick helper for fifo_wr_arbiter
package fifo_arb_pkg;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_BURST = 2'd1, S_STALL = 2'd2} arb_state_t;

   localparam int N_DEF     = 4;
   localparam int SIZE_DEF  = 8;
   localparam int TAM_DEF   = 32;
   localparam int BURST_DEF = 4;

   function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr, input int n);
      logic [2:0] k;
      rr_pick = ptr;
      for (int i = 7; i >= 0; i--) begin
         k = 3'((int'(ptr) + i) % n);
         if (i < n && req[k]) rr_pick = k;
      end
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_selector.sv
// rr_selector: cyclic priority encoder returning the first requester at or after ptr
module rr_selector
   import fifo_arb_pkg::*;
#(
   parameter int  N = N_DEF,
   localparam int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [W-1:0] idx,
   output logic         valid
);

   assign idx   = W'(rr_pick(8'(req), 3'(ptr), N));
   assign valid = |req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter for the FIFO write port; FIFO_ARB_PRIO0_EN makes requester 0 urgent
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int  N     = N_DEF,
   parameter int  size  = SIZE_DEF,
   parameter int  tam   = TAM_DEF,
   parameter int  BURST = BURST_DEF,
   localparam int W     = $clog2(N)
) (
   input  logic              CLOCK,
   input  logic              RESET_N,
   input  logic              CLEAR_N,
   input  logic [N-1:0]      REQ,
   input  logic [N*size-1:0] DATA_REQ,
   output logic [N-1:0]      ACK,
   input  logic              F_FULL_N,
   input  logic [5:0]        USE_DW,
   output logic              WRITE,
   output logic [size-1:0]   FIFO_DATA,
   output logic [W-1:0]      OWNER,
   output logic              BUSY
);

   arb_state_t             state, state_nx;
   logic [W-1:0]           rr_ptr, rr_ptr_nx, owner_nx, pick, grant_idx, ptr_inc;
   logic [3:0]             count, count_nx;
   logic                   pick_valid, space, accept, last_word, preempt, req_owner;
   logic [N-1:0][size-1:0] words;

   rr_selector #(.N(N)) u_sel (.req(REQ), .ptr(rr_ptr), .idx(pick), .valid(pick_valid));

   assign words     = DATA_REQ;
   assign space     = F_FULL_N && (({1'b0, USE_DW} + {6'd0, WRITE}) < 7'(tam));
   assign req_owner = REQ[OWNER];
   assign accept    = (state == S_BURST) && req_owner && space;
   assign last_word = ({1'b0, count} + 5'd1) == 5'(BURST);
   assign ptr_inc   = (OWNER == W'(N - 1)) ? '0 : OWNER + W'(1);

`ifdef FIFO_ARB_PRIO0_EN
   assign preempt   = REQ[0] && (OWNER != '0);
   assign grant_idx = REQ[0] ? '0 : pick;
`else
   assign preempt   = 1'b0;
   assign grant_idx = pick;
`endif

   // state register: FSM state, owner, rotation pointer and burst count
   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         state  <= S_IDLE;
         OWNER  <= '0;
         rr_ptr <= '0;
         count  <= '0;
      end else if (!CLEAR_N) begin
         state  <= S_IDLE;
         OWNER  <= '0;
         rr_ptr <= '0;
         count  <= '0;
      end else begin
         state  <= state_nx;
         OWNER  <= owner_nx;
         rr_ptr <= rr_ptr_nx;
         count  <= count_nx;
      end
   end

   // next state: grant in IDLE, count and end bursts, stall while the FIFO has no room
   always_comb begin
      state_nx  = state;
      owner_nx  = OWNER;
      rr_ptr_nx = rr_ptr;
      count_nx  = count;
      case (state)
         S_IDLE:
            if (pick_valid) begin
               state_nx = S_BURST;
               owner_nx = grant_idx;
               count_nx = '0;
            end
         S_BURST:
            if (!req_owner || (accept && (last_word || preempt))) begin
               state_nx  = S_IDLE;
               rr_ptr_nx = ptr_inc;
               count_nx  = '0;
            end else if (accept)
               count_nx = count + 4'd1;
            else if (!space)
               state_nx = S_STALL;
         S_STALL:
            if (!req_owner) begin
               state_nx  = S_IDLE;
               rr_ptr_nx = ptr_inc;
               count_nx  = '0;
            end else if (space)
               state_nx = S_BURST;
         default: state_nx = S_IDLE;
      endcase
   end

   // outputs: one-hot ACK to the owner when its word is taken, BUSY outside IDLE
   always_comb begin
      ACK        = '0;
      ACK[OWNER] = accept;
      BUSY       = state != S_IDLE;
   end

   // write port register: the accepted word reaches the FIFO one cycle after ACK
   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         WRITE     <= 1'b0;
         FIFO_DATA <= '0;
      end else if (!CLEAR_N) begin
         WRITE     <= 1'b0;
         FIFO_DATA <= '0;
      end else begin
         WRITE <= accept;
         if (accept) FIFO_DATA <= words[OWNER];
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: randomized scoreboard bench for fifo_wr_arbiter with an occupancy FIFO model behind it
module tb_fifo_wr_arbiter;

   localparam int N = 4, SZ = 8, TAM = 32, BL = 4, W = 2;

`ifdef FIFO_ARB_PRIO0_EN
   localparam bit PRIO = 1'b1;
`else
   localparam bit PRIO = 1'b0;
`endif

   logic            CLOCK = 1'b0, RESET_N = 1'b0, CLEAR_N = 1'b1;
   logic [N-1:0]    REQ = '0, ACK;
   logic [N*SZ-1:0] DATA_REQ = '0;
   logic            F_FULL_N, WRITE, BUSY;
   logic [5:0]      USE_DW;
   logic [SZ-1:0]   FIFO_DATA;
   logic [W-1:0]    OWNER;

   int vectors = 0, miscompares = 0;

   logic [SZ-1:0] rq [N][$];
   logic [SZ-1:0] exp_q [$];
   logic [N-1:0]  hold = '0, pop_mask = '0;
   int            occ = 0, f_val = 0;
   logic          rd = 1'b0, f_set = 1'b0;
   int            m_st = 0, m_own = 0, m_ptr = 0, m_cnt = 0, m_wr = 0;

   fifo_wr_arbiter #(.N(N), .size(SZ), .tam(TAM), .BURST(BL)) dut (
      .CLOCK(CLOCK), .RESET_N(RESET_N), .CLEAR_N(CLEAR_N), .REQ(REQ), .DATA_REQ(DATA_REQ),
      .ACK(ACK), .F_FULL_N(F_FULL_N), .USE_DW(USE_DW), .WRITE(WRITE), .FIFO_DATA(FIFO_DATA),
      .OWNER(OWNER), .BUSY(BUSY)
   );

   always #5 CLOCK = ~CLOCK;

   task automatic chk(string name, int act, int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   function automatic int first_from(logic [N-1:0] r, int p);
      for (int i = 0; i < N; i++)
         if (r[W'((p + i) % N)]) return (p + i) % N;
      return p;
   endfunction

   function automatic bit pending();
      for (int i = 0; i < N; i++)
         if (rq[i].size() > 0) return 1'b1;
      return 1'b0;
   endfunction

   // FIFO stand-in: only occupancy matters to the arbiter
   assign F_FULL_N = occ < TAM;
   assign USE_DW   = 6'(occ);
   always @(posedge CLOCK) occ <= f_set ? f_val : occ + int'(WRITE) - int'(rd && occ > 0);

   // monitor: every FIFO write must be the next word the model accepted
   always @(negedge CLOCK) begin
      if (RESET_N && WRITE) begin
         chk("wr_has_expect", int'(exp_q.size() > 0), 1);
         chk("wr_room", int'(occ < TAM), 1);
         if (exp_q.size() > 0) chk("fifo_data", int'(FIFO_DATA), int'(exp_q.pop_front()));
      end
   end

   // reference model: who holds the port and how many words of its burst are used
   always @(negedge CLOCK) begin : model
      int ea;
      bit sp, ends;
      if (!RESET_N) begin
         m_st = 0; m_own = 0; m_ptr = 0; m_cnt = 0; m_wr = 0;
         pop_mask = '0;
         exp_q.delete();
      end else begin
         sp = (occ < TAM) && (occ + m_wr < TAM);
         ea = (m_st == 1 && REQ[W'(m_own)] && sp) ? (1 << m_own) : 0;
         chk("ack", int'(ACK), ea);
         chk("owner", int'(OWNER), m_own);
         chk("busy", int'(BUSY), int'(m_st != 0));
         pop_mask = ACK;
         if (!CLEAR_N) begin
            m_st = 0; m_own = 0; m_ptr = 0; m_cnt = 0; m_wr = 0;
         end else begin
            if (ea != 0) exp_q.push_back(rq[m_own][0]);
            m_wr = int'(ea != 0);
            ends = 1'b0;
            if (m_st == 0) begin
               if (REQ != '0) begin
                  m_own = (PRIO && REQ[0]) ? 0 : first_from(REQ, m_ptr);
                  m_cnt = 0;
                  m_st  = 1;
               end
            end else if (!REQ[W'(m_own)])
               ends = 1'b1;
            else if (m_st == 1 && ea != 0) begin
               m_cnt++;
               ends = (m_cnt == BL) || (PRIO && REQ[0] && m_own != 0);
            end else if (m_st == 1)
               m_st = 2;
            else if (sp)
               m_st = 1;
            if (ends) begin
               m_ptr = (m_own + 1) % N;
               m_st  = 0;
            end
         end
      end
   end

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         REQ[i] = rq[i].size() > 0 && !hold[i];
         DATA_REQ[i*SZ +: SZ] = rq[i].size() > 0 ? rq[i][0] : '0;
      end
   endtask

   task automatic step(int n = 1);
      repeat (n) begin
         @(posedge CLOCK);
         #1;
         for (int i = 0; i < N; i++)
            if (pop_mask[i] && rq[i].size() > 0) void'(rq[i].pop_front());
         drive();
      end
   endtask

   task automatic push(int r, int n);
      repeat (n) rq[r].push_back(8'($urandom));
   endtask

   task automatic drain(int budget);
      int k = 0;
      while ((pending() || exp_q.size() > 0 || BUSY) && k < budget) begin
         step();
         k++;
      end
      chk("drain_in_budget", int'(k < budget), 1);
   endtask

   initial begin
      drive();
      step(2);
      chk("rst_write", int'(WRITE), 0);
      chk("rst_data", int'(FIFO_DATA), 0);
      chk("rst_owner", int'(OWNER), 0);
      chk("rst_busy", int'(BUSY), 0);
      chk("rst_ack", int'(ACK), 0);
      RESET_N = 1'b1;

      // lone requester 2, six words, empty FIFO
      push(2, 6); drive();
      drain(40);
      chk("occ_after_single", occ, 6);

      // clear arbiter and FIFO, then all four request
      CLEAR_N = 1'b0; f_set = 1'b1; f_val = 0;
      step();
      CLEAR_N = 1'b1; f_set = 1'b0;
      chk("clr_owner", int'(OWNER), 0);
      chk("clr_busy", int'(BUSY), 0);
      rd = 1'b1;
      for (int i = 0; i < N; i++) push(i, 8);
      drive();
      drain(200);

      // nearly full FIFO: two words fit, then stall
      rd = 1'b0; f_set = 1'b1; f_val = 30;
      step();
      f_set = 1'b0;
      push(1, 6); drive();
      step(8);
      chk("stall_use_dw", int'(USE_DW), 32);
      chk("stall_busy", int'(BUSY), 1);
      chk("stall_ack", int'(ACK), 0);
      rd = 1'b1;
      drain(100);

      // asynchronous reset in the middle of a burst
      push(1, 6); push(3, 3); drive();
      step(3);
      #1 RESET_N = 1'b0;
      #1;
      chk("arst_write", int'(WRITE), 0);
      chk("arst_ack", int'(ACK), 0);
      chk("arst_busy", int'(BUSY), 0);
      chk("arst_owner", int'(OWNER), 0);
      step(2);
      RESET_N = 1'b1;
      drain(100);

      // requester 3 withdraws while stalled on a full FIFO
      rd = 1'b0; CLEAR_N = 1'b0; f_set = 1'b1; f_val = 32;
      step();
      CLEAR_N = 1'b1; f_set = 1'b0;
      push(3, 2); drive();
      step(4);
      chk("stall_owner3", int'(OWNER), 3);
      chk("stall_busy3", int'(BUSY), 1);
      hold[3] = 1'b1; drive();
      step(2);
      chk("drop_idle", int'(BUSY), 0);
      f_set = 1'b1; f_val = 0; hold[3] = 1'b0;
      push(0, 3); drive();
      step();
      f_set = 1'b0;
      chk("grant_after_drop", int'(OWNER), 0);
      rd = 1'b1;
      drain(100);

      // random traffic with occasional clears and read throttling
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < N; i++)
            if ($urandom_range(0, 7) == 0) push(i, $urandom_range(1, 5));
         rd = $urandom_range(0, 3) != 0;
         CLEAR_N = $urandom_range(0, 99) != 0;
         drive();
         step();
      end
      CLEAR_N = 1'b1; rd = 1'b1;
      drain(1000);
      chk("scoreboard_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
